// File: rtl/spi_master_core.sv
// spi_master_core: 32-bit SPI master behind a 4-register memory-mapped interface.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting (default is MSB first).
module spi_master_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              miso,
    output logic              mosi,
    output logic              ss,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              interrupt,
    input  logic              sel,
    input  logic              read,
    input  logic              write
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_READY  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_INT_EN = ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, WAIT_FALL, SHIFT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   tx_shift, rx_shift, rx_hold, tx_hold;
    logic [DATA_W-1:0]   tx_next, rx_next, rd_mux;
    logic [CNT_W-1:0]    bit_cnt;
    logic                tx_bit, ready, int_en, busy;
    logic                sclk_meta, sclk_sync, sclk_prev;
    logic                sclk_rise, sclk_fall;
    logic                rd_en, wr_tx, wr_int_en, rd_rx;

    // Bus handshake: an access happens in any cycle where sel is high together with
    // read or write; there is no wait state, reads return data_out on the next cycle.
    assign rd_en     = sel && read;
    assign rd_rx     = rd_en && (address == ADDR_RX);
    assign wr_tx     = sel && write && (address == ADDR_TX);
    assign wr_int_en = sel && write && (address == ADDR_INT_EN);

    assign sclk_rise = sclk_sync && !sclk_prev;
    assign sclk_fall = !sclk_sync && sclk_prev;
    assign interrupt = ready && int_en;

    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        tx_bit  = tx_shift[0];
        tx_next = {1'b0, tx_shift[DATA_W-1:1]};
        rx_next = {miso, rx_shift[DATA_W-1:1]};
`else
        tx_bit  = tx_shift[DATA_W-1];
        tx_next = {tx_shift[DATA_W-2:0], 1'b0};
        rx_next = {rx_shift[DATA_W-2:0], miso};
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_RX:     rd_mux = rx_hold;
            ADDR_TX:     rd_mux = tx_hold;
            ADDR_READY:  rd_mux = {{(DATA_W-1){1'b0}}, ready};
            ADDR_INT_EN: rd_mux = {{(DATA_W-1){1'b0}}, int_en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // sclk idles high, so the synchronizer starts high to avoid a false edge
            sclk_meta <= 1'b1;
            sclk_sync <= 1'b1;
            sclk_prev <= 1'b1;
            state     <= IDLE;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            data_out  <= '0;
            ready     <= 1'b0;
            int_en    <= 1'b0;
            busy      <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_hold   <= '0;
            tx_hold   <= '0;
            bit_cnt   <= '0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            data_out  <= rd_en ? rd_mux : '0;

            if (wr_int_en)
                int_en <= data_in[0];
            // Completion below sets ready after this, so a colliding RX read loses.
            if (rd_rx)
                ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_tx) begin
                        tx_hold  <= data_in;
                        tx_shift <= data_in;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (sclk_fall) begin
                        ss       <= 1'b0;
                        mosi     <= tx_bit;
                        tx_shift <= tx_next;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (sclk_fall) begin
                        if (bit_cnt < LAST_BIT) begin
                            mosi     <= tx_bit;
                            tx_shift <= tx_next;
                        end else begin
                            ss      <= 1'b1;
                            mosi    <= 1'b0;
                            rx_hold <= rx_shift;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: bus reads/writes, a mode-3 slave model and an sclk monitor.
module tb_spi_master_core;

    logic        clk, rst, sclk, miso, mosi, ss, interrupt, sel, read, write;
    logic [31:0] data_in, data_out;
    logic [1:0]  address;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          slave_idx = 0;
    logic [31:0] mon_word = '0;
    logic [31:0] slave_word = '0;
    logic        slave_miso = 1'b0;
    logic        loopback = 1'b0;
    logic [31:0] rd;
    logic        got;

    spi_master_core #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .miso(miso), .mosi(mosi), .ss(ss),
        .data_in(data_in), .address(address), .data_out(data_out),
        .interrupt(interrupt), .sel(sel), .read(read), .write(write)
    );

    // clock / reset generation
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial sclk = 1'b1;
    always #50 sclk = ~sclk;

    assign miso = loopback ? mosi : slave_miso;

    // slave: present MSB when selected, advance on each sclk falling edge
    always @(negedge ss) begin
        slave_idx  = 31;
        slave_miso = slave_word[31];
    end
    always @(negedge sclk) begin
        if (!ss && slave_idx > 0) begin
            slave_idx  = slave_idx - 1;
            slave_miso = slave_word[slave_idx];
        end
    end

    // monitor: what the slave samples on each rising sclk edge while selected
    always @(posedge sclk) begin
        if (!ss) begin
            rise_cnt = rise_cnt + 1;
            mon_word = {mon_word[30:0], mosi};
        end
    end
    always @(posedge ss) done_cnt = done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; write = 1'b1; address = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; write = 1'b0; data_in = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = data_out;
        sel = 1'b0; read = 1'b0;
    endtask

    task automatic wait_ready(input int max_polls, output logic ok);
        logic [31:0] v;
        ok = 1'b0;
        for (int i = 0; i < max_polls && !ok; i++) begin
            bus_read(2'd2, v);
            if (v[0]) ok = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("reset_ss", {31'b0, ss}, 32'd1);
        check("reset_interrupt", {31'b0, interrupt}, 32'd0);
        check("reset_data_out", data_out, 32'd0);
        check("reset_mosi", {31'b0, mosi}, 32'd0);
        bus_read(2'd2, rd);
        check("reset_ready", rd, 32'd0);

        // polling transfer
        slave_word = 32'hA5A5A5A5; rise_cnt = 0; mon_word = '0;
        bus_write(2'd1, 32'hF0F0F0F0);
        wait_ready(400, got);
        check("poll_ready_seen", {31'b0, got}, 32'd1);
        check("poll_rise_count", rise_cnt, 32'd32);
        check("poll_mosi_word", mon_word, 32'hF0F0F0F0);
        check("poll_ss_idle", {31'b0, ss}, 32'd1);
        bus_read(2'd1, rd);
        check("poll_tx_readback", rd, 32'hF0F0F0F0);
        bus_read(2'd0, rd);
        check("poll_rx", rd, 32'hA5A5A5A5);
        @(negedge clk);
        check("idle_data_out_zero", data_out, 32'd0);
        bus_read(2'd2, rd);
        check("poll_ready_cleared", rd, 32'd0);

        // a TX write while ready=1 clears ready, RX keeps the old word
        slave_word = 32'hC3C31234;
        bus_write(2'd1, 32'h5A5A0FF0);
        wait_ready(400, got);
        check("second_ready_seen", {31'b0, got}, 32'd1);
        slave_word = 32'h3C3C96E1; mon_word = '0;
        bus_write(2'd1, 32'h00000000);
        bus_read(2'd2, rd);
        check("tx_clears_ready", rd, 32'd0);
        bus_read(2'd0, rd);
        check("rx_holds_old", rd, 32'hC3C31234);
        wait_ready(400, got);
        check("third_ready_seen", {31'b0, got}, 32'd1);
        bus_read(2'd0, rd);
        check("rx_new_word", rd, 32'h3C3C96E1);
        check("zero_mosi_word", mon_word, 32'd0);

        // interrupt with loopback
        bus_write(2'd3, 32'h00000001);
        bus_read(2'd3, rd);
        check("int_en_readback", rd, 32'd1);
        check("int_low_before", {31'b0, interrupt}, 32'd0);
        loopback = 1'b1;
        bus_write(2'd1, 32'hABABABAB);
        for (int i = 0; i < 1000 && !interrupt; i++) @(negedge clk);
        check("int_rises", {31'b0, interrupt}, 32'd1);
        bus_read(2'd0, rd);
        check("loopback_rx", rd, 32'hABABABAB);
        check("int_drops_after_rx", {31'b0, interrupt}, 32'd0);
        loopback = 1'b0;
        bus_write(2'd3, 32'h00000000);

        // a TX write while busy is ignored
        slave_word = 32'h0; rise_cnt = 0; mon_word = '0; done_cnt = 0;
        bus_write(2'd1, 32'h12345678);
        repeat (100) @(negedge clk);
        bus_write(2'd1, 32'hFFFFFFFF);
        wait_ready(400, got);
        check("busy_ready_seen", {31'b0, got}, 32'd1);
        check("busy_mosi_word", mon_word, 32'h12345678);
        check("busy_rise_count", rise_cnt, 32'd32);
        bus_read(2'd1, rd);
        check("busy_tx_readback", rd, 32'h12345678);
        repeat (400) @(negedge clk);
        check("busy_one_completion", done_cnt, 32'd1);
        bus_read(2'd0, rd);

        // reset in the middle of a transfer
        slave_word = 32'hDEADBEEF; rise_cnt = 0;
        bus_write(2'd1, 32'h0F0F1234);
        for (int i = 0; i < 2000 && rise_cnt < 10; i++) @(negedge clk);
        check("abort_reached_bit10", rise_cnt, 32'd10);
        rst = 1'b1;
        #1;
        check("abort_ss_immediate", {31'b0, ss}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd2, rd);
        check("abort_ready", rd, 32'd0);
        bus_read(2'd0, rd);
        check("abort_rx_zero", rd, 32'd0);

        slave_word = 32'h600DF00D; rise_cnt = 0; mon_word = '0;
        bus_write(2'd1, 32'h13572468);
        wait_ready(400, got);
        check("after_abort_ready", {31'b0, got}, 32'd1);
        check("after_abort_rises", rise_cnt, 32'd32);
        check("after_abort_mosi", mon_word, 32'h13572468);
        bus_read(2'd0, rd);
        check("after_abort_rx", rd, 32'h600DF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
